// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//   Turns a symbolic instruction request (mnemonic code plus register,
//   shift-amount, immediate and jump-target fields) into a 32-bit MIPS word.
//   It holds the word in a one-entry output register together with the byte
//   address the word belongs at in instruction memory.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
//   valid & ready are both 1. A producer holds valid and its payload stable
//   until that edge. in_ready is combinational (~out_valid | out_ready), so a
//   full register takes a new word in the same cycle its old word leaves.
//
// Ports
//   clock      : single clock, rising edge
//   reset      : asynchronous active-high reset
//   in_valid   : encode request valid
//   in_ready   : encoder can accept a request this cycle
//   mnem       : instruction code 0..19 (20..31 illegal)
//   rs/rt/rd/sa: register and shift-amount fields
//   imm        : 16-bit immediate
//   target     : 26-bit jump target
//   out_valid  : inst/addr hold a valid word; this is also the FSM state
//                (0 = EMPTY, 1 = FULL)
//   out_ready  : downstream accepts the word
//   inst       : encoded word
//   addr       : byte address of inst (bits [9:2] only, others always 0)
//   err        : sticky illegal-mnemonic flag
//   count      : words handed downstream, saturating at 256
// ----------------------------------------------------------------------------
module instr_encoder (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  sa,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic [31:0] addr,
    output logic        err,
    output logic [8:0]  count
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_inst;
    logic [7:0]  r_addr_idx;
    logic        r_err;
    logic [8:0]  r_count;

    logic        w_accept;
    logic        w_take;
    logic        w_legal;
    logic [31:0] w_word;

    assign in_ready = (r_state == ST_EMPTY) | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_take   = (r_state == ST_FULL) & out_ready;
    assign w_legal  = (mnem < 5'd20);

    // Encoder. Fields an encoding does not use are zeroed, not passed through.
    always_comb begin
        w_word = '0;
        case (mnem)
            5'd0:  w_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100000}; // add
            5'd1:  w_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100010}; // sub
            5'd2:  w_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100100}; // and
            5'd3:  w_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100101}; // or
            5'd4:  w_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100110}; // xor
            5'd5:  w_word = {6'b000000, 5'd0, rt, rd, sa, 6'b000000}; // sll
            5'd6:  w_word = {6'b000000, 5'd0, rt, rd, sa, 6'b000010}; // srl
            5'd7:  w_word = {6'b000000, 5'd0, rt, rd, sa, 6'b000011}; // sra
            5'd8:  w_word = {6'b000000, rs, 15'd0, 6'b001000};        // jr
            5'd9:  w_word = {6'b001000, rs, rt, imm};                 // addi
            5'd10: w_word = {6'b001100, rs, rt, imm};                 // andi
            5'd11: w_word = {6'b001101, rs, rt, imm};                 // ori
            5'd12: w_word = {6'b001110, rs, rt, imm};                 // xori
            5'd13: w_word = {6'b100011, rs, rt, imm};                 // lw
            5'd14: w_word = {6'b101011, rs, rt, imm};                 // sw
            5'd15: w_word = {6'b000100, rs, rt, imm};                 // beq
            5'd16: w_word = {6'b000101, rs, rt, imm};                 // bne
            5'd17: w_word = {6'b001111, 5'd0, rt, imm};               // lui
            5'd18: w_word = {6'b000010, target};                      // j
            5'd19: w_word = {6'b000011, target};                      // jal
            default: w_word = '0;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state. An illegal accept loads nothing, so the register only
    // empties if the current word leaves on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept && w_legal) begin
            w_state_nxt = ST_FULL;
        end else if (w_take) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // FSM: outputs
    always_comb begin
        out_valid = (r_state == ST_FULL);
    end

    // Datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inst     <= '0;
            r_addr_idx <= '0;
            r_err      <= 1'b0;
            r_count    <= '0;
        end else begin
            if (w_accept && w_legal) begin
                r_inst <= w_word;
            end
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
            end
            // Address and count move only when a word actually leaves.
            if (w_take) begin
                r_addr_idx <= r_addr_idx + 8'd1;
                if (r_count != 9'd256) begin
                    r_count <= r_count + 9'd1;
                end
            end
        end
    end

    assign inst  = r_inst;
    assign addr  = {22'd0, r_addr_idx, 2'b00};
    assign err   = r_err;
    assign count = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [25:0] target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
    logic [8:0]  count;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [4:0]  m;
        logic [4:0]  f_rs;
        logic [4:0]  f_rt;
        logic [4:0]  f_rd;
        logic [4:0]  f_sa;
        logic [15:0] f_imm;
        logic [25:0] f_tgt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    instr_encoder dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mnem      (mnem),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .sa        (sa),
        .imm       (imm),
        .target    (target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst      (inst),
        .addr      (addr),
        .err       (err),
        .count     (count)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic [4:0] m, input logic [4:0] f_rs,
                             input logic [4:0] f_rt, input logic [4:0] f_rd,
                             input logic [4:0] f_sa, input logic [15:0] f_imm,
                             input logic [25:0] f_tgt);
        in_valid = 1'b1;
        mnem     = m;
        rs       = f_rs;
        rt       = f_rt;
        rd       = f_rd;
        sa       = f_sa;
        imm      = f_imm;
        target   = f_tgt;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        mnem     = 5'($urandom_range(0, 31));
        rs       = 5'($urandom_range(0, 31));
        rt       = 5'($urandom_range(0, 31));
        rd       = 5'($urandom_range(0, 31));
        sa       = 5'($urandom_range(0, 31));
        imm      = 16'($urandom_range(0, 65535));
        target   = 26'($urandom);
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_inst"},  inst, 32'd0);
        chk({tag, "_addr"},  addr, 32'd0);
        chk({tag, "_err"},   {31'd0, err}, 32'd0);
        chk({tag, "_count"}, {23'd0, count}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vecs[0] = '{5'd8,  5'd31, 5'd1, 5'd1, 5'd1,  16'h5555, 26'h0, 32'h03E00008}; // jr
        vecs[1] = '{5'd7,  5'd5,  5'd6, 5'd7, 5'd31, 16'h0,    26'h0, 32'h00063FC3}; // sra
        vecs[2] = '{5'd17, 5'd9,  5'd3, 5'd0, 5'd0,  16'hABCD, 26'h0, 32'h3C03ABCD}; // lui
        vecs[3] = '{5'd15, 5'd1,  5'd2, 5'd9, 5'd9,  16'hFFFF, 26'h0, 32'h1022FFFF}; // beq
        vecs[4] = '{5'd18, 5'd4,  5'd4, 5'd4, 5'd4,  16'h1111, 26'h3FFFFFF, 32'h0BFFFFFF}; // j
        vecs[5] = '{5'd4,  5'd2,  5'd3, 5'd4, 5'd9,  16'h0,    26'h0, 32'h00432026}; // xor

        idle();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #3;
        chk_cleared("rst_during");
        #9;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_cleared("rst_after");

        // Single add; sa input must be ignored.
        drive_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 16'hBEEF, 26'h1234567);
        tick();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_inst", inst, 32'h00221820);
        chk("add_addr", addr, 32'd0);

        // Backpressure: pending word blocks new requests.
        drive_req(5'd1, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0, 26'h0);
        #1;
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        chk("bp_hold_inst", inst, 32'h00221820);
        chk("bp_hold_addr", addr, 32'd0);
        chk("bp_hold_count", {23'd0, count}, 32'd0);
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        idle();
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_drain_addr", addr, 32'd4);
        chk("bp_drain_count", {23'd0, count}, 32'd1);

        // Back-to-back stream lw, sw, jal with no bubbles.
        do_reset();
        out_ready = 1'b1;
        drive_req(5'd13, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
        exp_q.push_back(32'h8C080004);
        tick();
        chk("st0_valid", {31'd0, out_valid}, 32'd1);
        chk("st0_inst", inst, exp_q.pop_front());
        chk("st0_addr", addr, 32'd0);
        drive_req(5'd14, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
        exp_q.push_back(32'hAC080004);
        tick();
        chk("st1_valid", {31'd0, out_valid}, 32'd1);
        chk("st1_inst", inst, exp_q.pop_front());
        chk("st1_addr", addr, 32'd4);
        drive_req(5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010);
        exp_q.push_back(32'h0C000010);
        tick();
        chk("st2_valid", {31'd0, out_valid}, 32'd1);
        chk("st2_inst", inst, exp_q.pop_front());
        chk("st2_addr", addr, 32'd8);
        idle();
        tick();
        chk("st_end_valid", {31'd0, out_valid}, 32'd0);
        chk("st_end_addr", addr, 32'd12);
        chk("st_end_count", {23'd0, count}, 32'd3);

        // Illegal mnemonic on an empty register.
        out_ready = 1'b0;
        drive_req(5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
        tick();
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_no_valid", {31'd0, out_valid}, 32'd0);
        drive_req(5'd11, 5'd1, 5'd2, 5'd7, 5'd7, 16'h1234, 26'h0);
        tick();
        chk("ill_next_valid", {31'd0, out_valid}, 32'd1);
        chk("ill_next_inst", inst, 32'h34221234);
        chk("ill_next_err", {31'd0, err}, 32'd1);
        // Illegal accept while the current word leaves: register empties.
        out_ready = 1'b1;
        drive_req(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        tick();
        chk("ill_take_valid", {31'd0, out_valid}, 32'd0);
        chk("ill_take_inst", inst, 32'h34221234);
        chk("ill_take_addr", addr, 32'd16);
        chk("ill_take_count", {23'd0, count}, 32'd4);
        chk("ill_take_err", {31'd0, err}, 32'd1);

        // Encoding table streamed with out_ready=1.
        for (int i = 0; i < 6; i++) begin
            drive_req(vecs[i].m, vecs[i].f_rs, vecs[i].f_rt, vecs[i].f_rd,
                      vecs[i].f_sa, vecs[i].f_imm, vecs[i].f_tgt);
            exp_q.push_back(vecs[i].exp);
            tick();
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_inst", i), inst, exp_q.pop_front());
            chk($sformatf("vec%0d_addr", i), addr, 32'd16 + 32'(4 * i));
        end
        idle();
        tick();
        chk("vec_end_count", {23'd0, count}, 32'd10);

        // 257 handshakes: address wrap and count saturation.
        do_reset();
        out_ready = 1'b1;
        drive_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        tick();
        for (int i = 1; i <= 257; i++) begin
            tick();
            if (i == 255) begin
                chk("wrap_addr_3fc", addr, 32'h3FC);
                chk("wrap_count_255", {23'd0, count}, 32'd255);
            end
            if (i == 256) begin
                chk("wrap_addr_0", addr, 32'h000);
                chk("wrap_count_256", {23'd0, count}, 32'd256);
            end
        end
        chk("sat_addr", addr, 32'h004);
        chk("sat_count", {23'd0, count}, 32'd256);

        // Reset mid-stream between clock edges.
        drive_req(5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        tick();
        chk("pre_rst_err", {31'd0, err}, 32'd1);
        drive_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk_cleared("midrst");
        tick();
        chk_cleared("midrst_held");
        @(negedge clock);
        reset = 1'b0;
        drive_req(5'd5, 5'd7, 5'd2, 5'd4, 5'd3, 16'hFFFF, 26'h0);
        tick();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_inst", inst, 32'h000220C0);
        chk("post_rst_addr", addr, 32'd0);
        idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
